smi_frame_arbiter_xn: RTL and testbench

- N-input, one-output SMI frame arbiter.
- Parametrised successor of the two-way response arbiter used in the memory bus adaptors.
- Merges response (or request) streams from NumPorts SMI sources onto one SMI link.
- Grants whole frames only, using round-robin or fixed-priority policy, through a registered output stage that tags each flit with its source port.

---
 rtl/smi_frame_arbiter_xn.sv | 147 ++++++++++++++
 tb/tb_smi_frame_arbiter_xn.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/smi_frame_arbiter_xn.sv
// N-input SMI frame arbiter: grants whole frames (round-robin or fixed priority)
// and forwards them through a single registered output stage tagged with the source port.
module smi_frame_arbiter_xn #(
    parameter int FlitWidth    = 8,
    parameter int NumPorts     = 4,
    parameter int ArbMode      = 0,
    parameter int PortIdxWidth = 4
) (
    input  logic                              clk,
    input  logic                              srst,
    input  logic [NumPorts-1:0]               inReady,
    input  logic [NumPorts*8-1:0]             inEofc,
    input  logic [NumPorts*FlitWidth*8-1:0]   inData,
    output logic [NumPorts-1:0]               inStop,
    output logic                              outReady,
    output logic [7:0]                        outEofc,
    output logic [FlitWidth*8-1:0]            outData,
    output logic [PortIdxWidth-1:0]           outPort,
    input  logic                              outStop
);
    localparam int DataWidth = FlitWidth * 8;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                  state_reg, state_next;
    logic [PortIdxWidth-1:0] grant_reg, grant_next;
    logic [PortIdxWidth-1:0] ptr_reg, ptr_next;
    logic                    out_valid_reg, out_valid_next;
    logic [7:0]              out_eofc_reg, out_eofc_next;
    logic [DataWidth-1:0]    out_data_reg, out_data_next;
    logic [PortIdxWidth-1:0] out_port_reg, out_port_next;

    logic [7:0]              eofc_arr [NumPorts];
    logic [DataWidth-1:0]    data_arr [NumPorts];
    logic [NumPorts-1:0]     grant_onehot;
    logic                    sel_ready;
    logic [7:0]              sel_eofc;
    logic [DataWidth-1:0]    sel_data;
    logic                    can_accept;
    logic                    xfer;
    logic                    found_hi;
    logic [PortIdxWidth-1:0] pick_hi, pick_lo, pick;

    // Register can take a flit when empty or when its current flit drains this cycle.
    assign can_accept = ~out_valid_reg | ~outStop;

    generate
        for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port
            assign eofc_arr[gi]     = inEofc[8*gi +: 8];
            assign data_arr[gi]     = inData[DataWidth*gi +: DataWidth];
            assign grant_onehot[gi] = (state_reg == LOCKED) && (grant_reg == PortIdxWidth'(gi));
            assign inStop[gi]       = ~(grant_onehot[gi] & can_accept);
        end
    endgenerate

    always_comb begin
        sel_ready = 1'b0;
        sel_eofc  = '0;
        sel_data  = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (grant_onehot[i]) begin
                sel_ready = inReady[i];
                sel_eofc  = eofc_arr[i];
                sel_data  = data_arr[i];
            end
        end
    end

    assign xfer = sel_ready & can_accept;

    // Lowest requester at/above the pointer, else lowest overall (wrap).
    // In fixed-priority mode the pointer never leaves 0.
    always_comb begin
        found_hi = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int i = NumPorts - 1; i >= 0; i--) begin
            if (inReady[i] && (PortIdxWidth'(i) >= ptr_reg)) begin
                found_hi = 1'b1;
                pick_hi  = PortIdxWidth'(i);
            end
            if (inReady[i]) begin
                pick_lo = PortIdxWidth'(i);
            end
        end
        pick = found_hi ? pick_hi : pick_lo;
    end

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        ptr_next       = ptr_reg;
        out_valid_next = out_valid_reg & outStop;
        out_eofc_next  = out_eofc_reg;
        out_data_next  = out_data_reg;
        out_port_next  = out_port_reg;
        case (state_reg)
            IDLE: begin
                if (|inReady) begin
                    grant_next = pick;
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (xfer) begin
                    out_valid_next = 1'b1;
                    out_eofc_next  = sel_eofc;
                    out_data_next  = sel_data;
                    out_port_next  = grant_reg;
                    if (sel_eofc != 8'd0) begin
                        state_next = IDLE;
                        if (ArbMode == 0) begin
                            ptr_next = (grant_reg == PortIdxWidth'(NumPorts - 1)) ? '0 : grant_reg + 1'b1;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            ptr_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_eofc_reg  <= '0;
            out_data_reg  <= '0;
            out_port_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            ptr_reg       <= ptr_next;
            out_valid_reg <= out_valid_next;
            out_eofc_reg  <= out_eofc_next;
            out_data_reg  <= out_data_next;
            out_port_reg  <= out_port_next;
        end
    end

    assign outReady = out_valid_reg;
    assign outEofc  = out_eofc_reg;
    assign outData  = out_data_reg;
    assign outPort  = out_port_reg;

endmodule

// File: tb/tb_smi_frame_arbiter_xn.sv
// Directed bench: per-port flit sources feed a scoreboard; outputs popped and compared,
// plus per-cycle output history checked against expected frame order and bubbles.
module tb_smi_frame_arbiter_xn;
    localparam int FW = 8;
    localparam int NP = 4;
    localparam int PW = 4;
    localparam int DW = FW * 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              srst;
    logic [NP-1:0]     inReady;
    logic [NP*8-1:0]   inEofc;
    logic [NP*DW-1:0]  inData;
    logic              outStop;
    logic              sel_fp;

    logic [NP-1:0] r_inStop, f_inStop, inStop;
    logic          r_outReady, f_outReady, outReady;
    logic [7:0]    r_outEofc, f_outEofc, outEofc;
    logic [DW-1:0] r_outData, f_outData, outData;
    logic [PW-1:0] r_outPort, f_outPort, outPort;

    smi_frame_arbiter_xn #(.FlitWidth(FW), .NumPorts(NP), .ArbMode(0), .PortIdxWidth(PW)) dut_rr (
        .clk(clk), .srst(srst), .inReady(inReady), .inEofc(inEofc), .inData(inData),
        .inStop(r_inStop), .outReady(r_outReady), .outEofc(r_outEofc), .outData(r_outData),
        .outPort(r_outPort), .outStop(outStop));

    smi_frame_arbiter_xn #(.FlitWidth(FW), .NumPorts(NP), .ArbMode(1), .PortIdxWidth(PW)) dut_fp (
        .clk(clk), .srst(srst), .inReady(inReady), .inEofc(inEofc), .inData(inData),
        .inStop(f_inStop), .outReady(f_outReady), .outEofc(f_outEofc), .outData(f_outData),
        .outPort(f_outPort), .outStop(outStop));

    assign inStop   = sel_fp ? f_inStop   : r_inStop;
    assign outReady = sel_fp ? f_outReady : r_outReady;
    assign outEofc  = sel_fp ? f_outEofc  : r_outEofc;
    assign outData  = sel_fp ? f_outData  : r_outData;
    assign outPort  = sel_fp ? f_outPort  : r_outPort;

    logic [71:0] src_mem [NP][32];
    int          head [NP];
    int          tail [NP];
    logic [75:0] sb_q[$];
    int          hist[$];
    int          exp_hist[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          out_count;
    logic        stall_prev;
    logic [76:0] stall_saved;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic add_frame(input int p, input int nflits, input logic [7:0] last_eofc);
        for (int i = 0; i < nflits; i++) begin
            src_mem[p][tail[p]] = {((i == nflits - 1) ? last_eofc : 8'h00),
                                   8'(p), 8'(i), 16'(tail[p]), 32'($urandom)};
            tail[p]++;
        end
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            if (head[p] < tail[p]) begin
                inReady[p]        = 1'b1;
                inEofc[8*p +: 8]  = src_mem[p][head[p]][71:64];
                inData[DW*p +: DW] = src_mem[p][head[p]][63:0];
            end else begin
                inReady[p]        = 1'b0;
                inEofc[8*p +: 8]  = 8'h00;
                inData[DW*p +: DW] = '0;
            end
        end
    endtask

    // One clock: sample at negedge, account transfers, advance sources after the edge.
    task automatic step();
        logic [76:0] now_v;
        logic [75:0] exp_flit;
        @(negedge clk);
        now_v = {outReady, outPort, outEofc, outData};
        if (stall_prev) check("hold_stable", now_v, stall_saved);
        stall_prev  = outReady && outStop;
        stall_saved = now_v;
        if (outReady && outStop) check("stop_when_full", inStop, {NP{1'b1}});
        check("single_grant", ($countones(~inStop) <= 1), 1);
        hist.push_back(outReady ? int'(outPort) : -1);
        if (outReady && !outStop) begin
            out_count++;
            check("sb_pending", (sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                exp_flit = sb_q.pop_front();
                check("flit", {outPort, outEofc, outData}, exp_flit);
                $display("out flit port=%0d eofc=%0d data=%h", outPort, outEofc, outData);
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (inReady[p] && !inStop[p]) begin
                sb_q.push_back({4'(p), src_mem[p][head[p]]});
                head[p]++;
            end
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_drain(input int budget);
        int pending;
        for (int c = 0; c < budget; c++) begin
            pending = sb_q.size() + int'(outReady);
            for (int p = 0; p < NP; p++) pending += tail[p] - head[p];
            if (pending == 0) break;
            step();
        end
        pending = sb_q.size() + int'(outReady);
        for (int p = 0; p < NP; p++) pending += tail[p] - head[p];
        check("drained", pending, 0);
        step();
        step();
    endtask

    task automatic do_reset();
        srst    = 1'b1;
        outStop = 1'b0;
        step();
        step();
        srst = 1'b0;
        for (int p = 0; p < NP; p++) begin
            head[p] = 0;
            tail[p] = 0;
        end
        sb_q.delete();
        hist.delete();
        out_count  = 0;
        stall_prev = 1'b0;
        drive();
    endtask

    task automatic check_hist(input string tag);
        for (int i = 0; i < exp_hist.size(); i++) begin
            check(tag, hist[i], exp_hist[i]);
        end
    endtask

    task automatic eh(input int v);
        exp_hist.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        srst = 1'b1; outStop = 1'b0; sel_fp = 1'b0;
        inReady = '0; inEofc = '0; inData = '0;
        stall_prev = 1'b0; out_count = 0;
        for (int p = 0; p < NP; p++) begin
            head[p] = 0;
            tail[p] = 0;
        end

        do_reset();
        check("rst_outReady", outReady, 0);
        check("rst_inStop", inStop, 4'hF);
        check("rst_outPort", outPort, 0);
        check("rst_outEofc", outEofc, 0);
        check("rst_outData", outData, 0);

        // Single 3-flit frame from port 2: output in cycles N+2..N+4.
        add_frame(2, 3, 8'd8);
        drive();
        run_drain(20);
        exp_hist.delete();
        eh(-1); eh(-1); eh(2); eh(2); eh(2); eh(-1);
        check_hist("single_frame");
        check("single_count", out_count, 3);

        // Round-robin across all four ports, 2-flit frames, one bubble between frames.
        do_reset();
        for (int f = 0; f < 3; f++)
            for (int p = 0; p < NP; p++)
                add_frame(p, 2, (p == 3 && f == 1) ? 8'hFF : 8'(p + 5));
        drive();
        run_drain(100);
        exp_hist.delete();
        eh(-1); eh(-1);
        for (int f = 0; f < 6; f++) begin
            eh(f % 4); eh(f % 4);
            if (f < 5) eh(-1);
        end
        check_hist("rr_order");
        check("rr_count", out_count, 24);

        // Fixed priority: port 1 always beats port 3.
        sel_fp = 1'b1;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            add_frame(1, 2, 8'd8);
            add_frame(3, 2, 8'd4);
        end
        drive();
        run_drain(100);
        exp_hist.delete();
        eh(-1); eh(-1);
        for (int f = 0; f < 6; f++) begin
            eh((f < 3) ? 1 : 3); eh((f < 3) ? 1 : 3);
            if (f < 5) eh(-1);
        end
        check_hist("fp_order");
        sel_fp = 1'b0;

        // Backpressure for 5 cycles mid-frame.
        do_reset();
        add_frame(0, 4, 8'd6);
        drive();
        step(); step(); step();
        outStop = 1'b1;
        repeat (5) step();
        outStop = 1'b0;
        run_drain(20);
        check("bp_count", out_count, 4);

        // Port 1 requests while port 0 is mid-frame: no interleave.
        do_reset();
        add_frame(0, 3, 8'd3);
        drive();
        step(); step();
        add_frame(1, 2, 8'd8);
        drive();
        run_drain(30);
        exp_hist.delete();
        eh(-1); eh(-1); eh(0); eh(0); eh(0); eh(-1); eh(1); eh(1); eh(-1);
        check_hist("no_interleave");

        // Single-flit frame from port 1 moves the pointer to 2, then reset mid-frame.
        do_reset();
        add_frame(1, 1, 8'd2);
        drive();
        run_drain(20);
        exp_hist.delete();
        eh(-1); eh(-1); eh(1); eh(-1);
        check_hist("single_flit");
        add_frame(2, 4, 8'd8);
        drive();
        step(); step(); step();
        do_reset();
        check("midrst_outReady", outReady, 0);
        check("midrst_inStop", inStop, 4'hF);
        check("midrst_outPort", outPort, 0);
        add_frame(0, 2, 8'd1);
        add_frame(3, 2, 8'd8);
        drive();
        run_drain(30);
        exp_hist.delete();
        eh(-1); eh(-1); eh(0); eh(0); eh(-1); eh(3); eh(3); eh(-1);
        check_hist("post_reset_rr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
